mac_sequencer: RTL
==================

Name: mac_sequencer

Overview:
Multiply-accumulate front end that sits directly around the 16x16 signed sequential multiplier.
- Accepts a stream of signed operand pairs on a valid/ready interface.
- Issues each pair to the multiplier over its level Start/Done handshake.
- Sign-extends each 32-bit product and accumulates it.
- Presents the dot-product result on a valid/ready output when the last pair of a vector has been accumulated.

Parameters:
ACC_WIDTH, 40, accumulator and Out_Acc width in bits; legal range 32..64.
CNT_WIDTH, 16, width of the term counter Out_Count.

Ports:
Clock  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
In_Valid  input  1  operand pair valid.
In_Ready  output  1  sequencer can accept a pair.
In_A  input  16  signed operand, driven to Mul_Multiplier.
In_B  input  16  signed operand, driven to Mul_Multiplicand.
In_Last  input  1  pair is the final term of the current vector.
Clear  input  1  synchronous clear of accumulator, count and Overflow.
Mul_Start  output  1  level start to the multiplier.
Mul_Multiplier  output  16  latched In_A.
Mul_Multiplicand  output  16  latched In_B.
Mul_Product  input  32  signed product from the multiplier.
Mul_Done  input  1  multiplier done level.
Out_Valid  output  1  result valid.
Out_Ready  input  1  consumer accepts the result.
Out_Acc  output  ACC_WIDTH  signed accumulated sum.
Out_Count  output  CNT_WIDTH  number of terms accumulated.
Overflow  output  1  sticky accumulator overflow flag.

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE; all of the following are 0:
  - Mul_Start, Mul_Multiplier, Mul_Multiplicand
  - Out_Valid, Out_Acc, Out_Count, Overflow
  - internal product and last registers
- Reset mid-operation abandons the term. The multiplier shares the reset and is expected to return to its idle state too.
- All outputs are registered except In_Ready. In_Ready = (state==IDLE) && !Clear && !Mul_Done.
- State IDLE:
  - If Clear: zero the accumulator, Out_Count and Overflow; stay in IDLE. Clear has priority over In_Valid, and no pair is accepted that cycle.
  - Else, on In_Valid && In_Ready: latch In_A, In_B and In_Last; set Mul_Start=1; go to WAIT.
  - Clear is ignored in all other states.
- State WAIT:
  - Mul_Start held 1; operand outputs held stable.
  - When Mul_Done=1: capture Mul_Product; set Mul_Start=0; go to DRAIN.
  - No timeout.
- State DRAIN:
  - Mul_Start=0; operands still held.
  - When Mul_Done=0: go to ACCUM.
  - This guarantees that the multiplier's done level from the previous term is never mistaken for completion of the next one.
- State ACCUM (exactly 1 cycle):
  - acc <= acc + sign_extend(product, ACC_WIDTH).
  - Out_Count increments and saturates at all-ones.
  - If the latched last flag is set: go to OUTPUT. Otherwise go to IDLE.
- State OUTPUT:
  - Out_Valid=1; Out_Acc and Out_Count held stable.
  - On Out_Ready: Out_Valid=0; accumulator, Out_Count and Overflow zeroed; go to IDLE.
- Out_Acc continuously mirrors the accumulator register, but is only meaningful while Out_Valid=1.
- Per-term latency: accept edge + 1 cycle of Start + multiplier latency + drain (at least 1 cycle) + 1 ACCUM cycle.
  - With an L-cycle multiplier, the minimum is L+4 cycles between accepts.
  - A last term gives Out_Valid L+4 cycles after accept.
- Signed overflow is detected as: operand signs equal and result sign differs, evaluated at ACC_WIDTH.

Optional Feature:
Macro MAC_SAT_EN.
- Defined: on overflow, the accumulator clamps to the signed max (2^(ACC_WIDTH-1)-1) or signed min (-2^(ACC_WIDTH-1)) according to the product's sign, and Overflow sets sticky until Clear, reset, or an output handshake.
- Not defined: the accumulator wraps modulo 2^ACC_WIDTH, and Overflow is tied to 0.

Test Plan:
- Basic vector, ACC_WIDTH=40, behavioural multiplier with latency 5: pairs (3,4), (-2,5) last.
  - Required: Out_Acc=2, Out_Count=2, Out_Valid after the second term.
  - Mul_Start never rises while Mul_Done=1.
- Backpressure: Out_Ready held 0 for 10 cycles.
  - Out_Valid and Out_Acc are stable and In_Ready=0 throughout.
  - Handshake on cycle 11 clears the count. The next vector (7,-7) last gives Out_Acc=-49 (0xFFFFFFFFCF at 40 bits).
- Clear: accumulate (100,100) non-last, then pulse Clear in IDLE together with In_Valid.
  - The pair is not accepted that cycle.
  - The following (1,1) last gives Out_Acc=1, Out_Count=1.
- Saturation, ACC_WIDTH=32, MAC_SAT_EN defined: three pairs (32767,32767), last on the third (0x3FFF0001 each).
  - Required: Out_Acc=0x7FFFFFFF, Overflow=1.
  - Same run without the macro: Out_Acc=0xBFFD0003, Overflow=0.
- Reset mid-operation: drop Reset_n during WAIT.
  - Immediately: Mul_Start=0, Out_Valid=0, Out_Acc=0, In_Ready=1 once Mul_Done is low.
  - A subsequent (2,3) last gives Out_Acc=6.
- Real multiplier in loop: (-300,25) then (1000,-2) last.
  - Required: Out_Acc=-9500 (0xFFFFFFDAE4 at 40 bits), Out_Count=2.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: multiply-accumulate front end around a 16x16 signed
// sequential multiplier with a level Start/Done handshake.
// Operand pairs arrive on a valid/ready input. Each pair is issued to the
// multiplier, and the 32-bit product is sign-extended and accumulated.
// The dot product is presented on a valid/ready output after the last term.
// Optional build macro MAC_SAT_EN: saturating accumulation with a sticky
// Overflow flag. Without it the accumulator wraps and Overflow stays 0.
module mac_sequencer #(
    parameter int ACC_WIDTH = 40,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [15:0]          In_A,
    input  logic [15:0]          In_B,
    input  logic                 In_Last,
    input  logic                 Clear,
    output logic                 Mul_Start,
    output logic [15:0]          Mul_Multiplier,
    output logic [15:0]          Mul_Multiplicand,
    input  logic [31:0]          Mul_Product,
    input  logic                 Mul_Done,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [ACC_WIDTH-1:0] Out_Acc,
    output logic [CNT_WIDTH-1:0] Out_Count,
    output logic                 Overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t               state;
    logic [31:0]          prod_q;
    logic                 last_q;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;

`ifdef MAC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic ovf;
`endif

    // Refuse a pair while Clear is pending, and while the multiplier still
    // shows a stale done level, so Start never rises on top of Done.
    assign In_Ready = (state == S_IDLE) && !Clear && !Mul_Done;

    // The product is sign-extended to the accumulator width, then added.
    assign prod_ext = ACC_WIDTH'($signed(prod_q));
    assign sum      = Out_Acc + prod_ext;

`ifdef MAC_SAT_EN
    // Signed overflow: both addends have the same sign and the sum's sign differs.
    assign ovf = (Out_Acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                 (sum[ACC_WIDTH-1] != Out_Acc[ACC_WIDTH-1]);
`endif

    // Sequencer FSM. All outputs except In_Ready are registered here.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state            <= S_IDLE;
            Mul_Start        <= 1'b0;
            Mul_Multiplier   <= '0;
            Mul_Multiplicand <= '0;
            prod_q           <= '0;
            last_q           <= 1'b0;
            Out_Valid        <= 1'b0;
            Out_Acc          <= '0;
            Out_Count        <= '0;
            Overflow         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Clear) begin
                        Out_Acc   <= '0;
                        Out_Count <= '0;
                        Overflow  <= 1'b0;
                    end else if (In_Valid && In_Ready) begin
                        Mul_Multiplier   <= In_A;
                        Mul_Multiplicand <= In_B;
                        last_q           <= In_Last;
                        Mul_Start        <= 1'b1;
                        state            <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (Mul_Done) begin
                        prod_q    <= Mul_Product;
                        Mul_Start <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Wait for Done to fall so it cannot be read as the next term's completion.
                    if (!Mul_Done) begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
`ifdef MAC_SAT_EN
                    if (ovf) begin
                        Out_Acc  <= prod_ext[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
                        Overflow <= 1'b1;
                    end else begin
                        Out_Acc <= sum;
                    end
`else
                    Out_Acc <= sum;
`endif
                    if (Out_Count != {CNT_WIDTH{1'b1}}) begin
                        Out_Count <= Out_Count + 1'b1;
                    end
                    if (last_q) begin
                        Out_Valid <= 1'b1;
                        state     <= S_OUTPUT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OUTPUT: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        Out_Acc   <= '0;
                        Out_Count <= '0;
                        Overflow  <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
